// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared types and constants for the multi-cycle RV64 core
package rv_core_pkg;

   typedef enum logic [2:0] {
      FETCH,
      IWAIT,
      EXEC,
      MEM,
      DWAIT,
      WB,
      HALT,
      TRAP
   } state_t;

   localparam logic [1:0]  CAUSE_NONE     = 2'd0;
   localparam logic [1:0]  CAUSE_ILLEGAL  = 2'd1;
   localparam logic [1:0]  CAUSE_MISALIGN = 2'd2;

   localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
   localparam int          INST_BYTES     = 4;

endpackage

// File: rtl/rv_perf_cnt.sv
// rtl/rv_perf_cnt.sv - mcycle/minstret counter pair with freeze and retire inputs
module rv_perf_cnt #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            inc_instret,
   output logic [XLEN-1:0] mcycle,
   output logic [XLEN-1:0] minstret
);

   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (!freeze) begin
            mcycle <= mcycle + ONE;
         end
         if (inc_instret) begin
            minstret <= minstret + ONE;
         end
      end
   end

endmodule

// File: rtl/rv_multi_cyc_ctrl.sv
// rtl/rv_multi_cyc_ctrl.sv - multi-cycle sequencer owning pc, instruction register and handshakes
module rv_multi_cyc_ctrl
   import rv_core_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
   parameter int              ILEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [ILEN-1:0] inst_o,
   output logic [PC_W-1:0] pc,
   input  logic            dec_ebreak,
   input  logic            dec_invalid,
   input  logic            dec_mem,
   input  logic            dec_rd_we,
   input  logic            jump_flag,
   input  logic [PC_W-1:0] jump_addr,
   output logic            dmem_req,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   output logic            rd_w_en,
   output logic            halt,
   output logic            trap,
   output logic [1:0]      trap_cause,
   output logic [XLEN-1:0] mcycle,
   output logic [XLEN-1:0] minstret
);

   state_t          state;
   state_t          state_n;
   logic [1:0]      cause_n;
   logic            load_inst;
   logic [PC_W-1:0] pc_next;

   assign imem_addr = pc;
   assign pc_next   = jump_flag ? jump_addr : pc + PC_W'(INST_BYTES);

   // Grants only count while our registered request is actually up, so a
   // stray grant in the first cycle after reset cannot start a fetch.
   always_comb begin
      state_n   = state;
      cause_n   = trap_cause;
      load_inst = 1'b0;
      case (state)
         FETCH: begin
            if (imem_req && imem_gnt) begin
               if (imem_rvalid) begin
                  state_n   = EXEC;
                  load_inst = 1'b1;
               end else begin
                  state_n = IWAIT;
               end
            end
         end
         IWAIT: begin
            if (imem_rvalid) begin
               state_n   = EXEC;
               load_inst = 1'b1;
            end
         end
         EXEC: begin
            if (dec_invalid) begin
               state_n = TRAP;
               cause_n = CAUSE_ILLEGAL;
            end else if (dec_ebreak) begin
               state_n = HALT;
            end else if (jump_flag && (jump_addr[1:0] != 2'b00)) begin
               state_n = TRAP;
               cause_n = CAUSE_MISALIGN;
            end else if (dec_mem) begin
               state_n = MEM;
            end else begin
               state_n = WB;
            end
         end
         MEM: begin
            if (dmem_req && dmem_gnt) begin
               state_n = dmem_rvalid ? WB : DWAIT;
            end
         end
         DWAIT: begin
            if (dmem_rvalid) begin
               state_n = WB;
            end
         end
         WB:      state_n = FETCH;
         HALT:    state_n = HALT;
         TRAP:    state_n = TRAP;
         default: state_n = FETCH;
      endcase
   end

   // Outputs are registered off the next state so each is valid for the
   // whole cycle the FSM spends in the corresponding state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         inst_o     <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         rd_w_en    <= 1'b0;
         halt       <= 1'b0;
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
      end else begin
         state      <= state_n;
         imem_req   <= (state_n == FETCH);
         dmem_req   <= (state_n == MEM);
         rd_w_en    <= (state_n == WB) && dec_rd_we;
         halt       <= (state_n == HALT);
         trap       <= (state_n == TRAP);
         trap_cause <= cause_n;
         if (load_inst) begin
            inst_o <= imem_rdata;
         end
         if (state == WB) begin
            pc <= pc_next;
         end
      end
   end

   rv_perf_cnt #(
      .XLEN(XLEN)
   ) u_perf_cnt (
      .clk        (clk),
      .rst        (rst),
      .freeze     ((state == HALT) || (state == TRAP)),
      .inc_instret(state == WB),
      .mcycle     (mcycle),
      .minstret   (minstret)
   );

endmodule

// File: tb/tb_rv_multi_cyc_ctrl.sv
// tb/tb_rv_multi_cyc_ctrl.sv - directed scoreboard bench for rv_multi_cyc_ctrl
module tb_rv_multi_cyc_ctrl;

   localparam int          XLEN = 64;
   localparam int          PC_W = 32;
   localparam int          ILEN = 32;
   localparam logic [31:0] RPC  = 32'h8000_0000;

   // instruction word flag bits understood by the bench decoder
   localparam int B_MEM  = 27;
   localparam int B_RDWE = 28;
   localparam int B_EBRK = 29;
   localparam int B_INV  = 30;
   localparam int B_JMP  = 31;

   logic            clk = 1'b0;
   logic            rst;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [ILEN-1:0] imem_rdata;
   logic [ILEN-1:0] inst_o;
   logic [PC_W-1:0] pc;
   logic            dec_ebreak;
   logic            dec_invalid;
   logic            dec_mem;
   logic            dec_rd_we;
   logic            jump_flag;
   logic [PC_W-1:0] jump_addr;
   logic            dmem_req;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic            rd_w_en;
   logic            halt;
   logic            trap;
   logic [1:0]      trap_cause;
   logic [XLEN-1:0] mcycle;
   logic [XLEN-1:0] minstret;

   logic [31:0] jtgt;
   logic [31:0] m_pc;
   logic [63:0] m_ret;
   logic [63:0] mc_snap;
   logic [31:0] w;
   logic [31:0] exp_fetch[$];
   logic [31:0] exp_inst[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   assign dec_mem     = inst_o[B_MEM];
   assign dec_rd_we   = inst_o[B_RDWE];
   assign dec_ebreak  = inst_o[B_EBRK];
   assign dec_invalid = inst_o[B_INV];
   assign jump_flag   = inst_o[B_JMP];
   assign jump_addr   = jtgt;

   rv_multi_cyc_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .inst_o     (inst_o),
      .pc         (pc),
      .dec_ebreak (dec_ebreak),
      .dec_invalid(dec_invalid),
      .dec_mem    (dec_mem),
      .dec_rd_we  (dec_rd_we),
      .jump_flag  (jump_flag),
      .jump_addr  (jump_addr),
      .dmem_req   (dmem_req),
      .dmem_gnt   (dmem_gnt),
      .dmem_rvalid(dmem_rvalid),
      .rd_w_en    (rd_w_en),
      .halt       (halt),
      .trap       (trap),
      .trap_cause (trap_cause),
      .mcycle     (mcycle),
      .minstret   (minstret)
   );

   function automatic logic [31:0] mk(input logic mem, input logic rdwe, input logic ebrk,
                                      input logic inv, input logic jmp, input logic [7:0] tag);
      mk = {jmp, inv, ebrk, rdwe, mem, 19'd0, tag};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_fetch.delete();
      exp_inst.delete();
      m_pc  = RPC;
      m_ret = 0;
      exp_fetch.push_back(RPC);
   endtask

   // Runs the fetch handshake and returns at the negedge of the EXEC cycle.
   task automatic fetch(input logic [31:0] word, input int gd, input int rd);
      int          n;
      logic [31:0] pc0;
      logic [31:0] inst0;
      logic [31:0] e;
      n = 0;
      while (imem_req !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check("imem_req_seen", imem_req, 1);
      e = exp_fetch.pop_front();
      check("fetch_addr", imem_addr, e);
      pc0   = pc;
      inst0 = inst_o;
      for (int i = 0; i < gd; i++) begin
         @(negedge clk);
         check("imem_req_held", imem_req, 1);
      end
      imem_gnt    = 1'b1;
      imem_rdata  = word;
      imem_rvalid = (rd == 0);
      exp_inst.push_back(word);
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (rd > 0) begin
         check("imem_req_dropped", imem_req, 0);
         for (int i = 1; i < rd; i++) begin
            @(negedge clk);
         end
         check("inst_before_rvalid", inst_o, inst0);
         check("pc_during_iwait", pc, pc0);
         imem_rvalid = 1'b1;
         @(negedge clk);
         imem_rvalid = 1'b0;
      end
      e = exp_inst.pop_front();
      check("inst_latched", inst_o, e);
      check("pc_in_exec", pc, pc0);
   endtask

   // From the EXEC negedge of a retiring instruction through WB into FETCH.
   task automatic finish_instr(input logic [31:0] word, input int dgd, input int drd);
      @(negedge clk);
      if (word[B_MEM]) begin
         check("dmem_req_set", dmem_req, 1);
         for (int i = 0; i < dgd; i++) begin
            @(negedge clk);
            check("dmem_req_held", dmem_req, 1);
         end
         dmem_gnt    = 1'b1;
         dmem_rvalid = (drd == 0);
         @(negedge clk);
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
         if (drd > 0) begin
            check("dmem_req_dropped", dmem_req, 0);
            for (int i = 1; i < drd; i++) begin
               @(negedge clk);
            end
            check("rd_w_en_before_rvalid", rd_w_en, 0);
            dmem_rvalid = 1'b1;
            @(negedge clk);
            dmem_rvalid = 1'b0;
         end
      end
      check("rd_w_en_wb", rd_w_en, word[B_RDWE]);
      check("pc_in_wb", pc, m_pc);
      m_pc  = word[B_JMP] ? jtgt : m_pc + 32'd4;
      m_ret = m_ret + 1;
      exp_fetch.push_back(m_pc);
      @(negedge clk);
      check("rd_w_en_one_cycle", rd_w_en, 0);
      check("pc_after_wb", pc, m_pc);
      check("minstret", minstret, m_ret);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      jtgt = '0;
      do_reset();
      check("rst_pc", pc, RPC);
      check("rst_inst", inst_o, 0);
      check("rst_imem_req", imem_req, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_rd_w_en", rd_w_en, 0);
      check("rst_halt", halt, 0);
      check("rst_trap", trap, 0);
      check("rst_cause", trap_cause, 0);
      check("rst_mcycle", mcycle, 0);
      check("rst_minstret", minstret, 0);

      // addi stream, zero-wait memory
      for (int k = 0; k < 5; k++) begin
         w = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(k));
         fetch(w, 0, 0);
         finish_instr(w, 0, 0);
      end
      check("stream_minstret", minstret, 5);
      check("stream_mcycle", mcycle, 16);

      // slow instruction memory
      w = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
      fetch(w, 3, 2);
      finish_instr(w, 0, 0);

      // aligned jump, then a misaligned one
      jtgt = 32'h8000_0100;
      w = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30);
      fetch(w, 0, 0);
      finish_instr(w, 0, 0);
      jtgt = 32'h8000_0102;
      w = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h31);
      fetch(w, 0, 0);
      @(negedge clk);
      check("misalign_trap", trap, 1);
      check("misalign_cause", trap_cause, 2);
      check("misalign_pc", pc, 32'h8000_0100);
      mc_snap = mcycle;
      repeat (4) @(negedge clk);
      check("trap_no_imem_req", imem_req, 0);
      check("trap_no_dmem_req", dmem_req, 0);
      check("trap_mcycle_frozen", mcycle, mc_snap);
      check("trap_pc_held", pc, 32'h8000_0100);

      // load with gnt and rvalid four cycles apart
      do_reset();
      w = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
      fetch(w, 0, 0);
      finish_instr(w, 1, 4);
      check("load_minstret", minstret, 1);

      // ebreak as third instruction
      do_reset();
      for (int k = 0; k < 2; k++) begin
         w = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + k));
         fetch(w, 0, 0);
         finish_instr(w, 0, 0);
      end
      w = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h52);
      fetch(w, 0, 0);
      @(negedge clk);
      check("halt_set", halt, 1);
      check("halt_minstret", minstret, 2);
      check("halt_mcycle", mcycle, 9);
      repeat (4) @(negedge clk);
      check("halt_mcycle_frozen", mcycle, 9);
      check("halt_no_imem_req", imem_req, 0);
      check("halt_pc_held", pc, RPC + 32'd8);
      check("halt_no_rd_w_en", rd_w_en, 0);
      do_reset();
      check("post_halt_pc", pc, RPC);
      check("post_halt_halt", halt, 0);
      check("post_halt_mcycle", mcycle, 0);
      check("post_halt_minstret", minstret, 0);

      // reset in DWAIT with stray responses afterwards
      w = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60);
      fetch(w, 0, 0);
      @(negedge clk);
      check("abort_dmem_req", dmem_req, 1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rd_w_en", rd_w_en, 0);
      check("abort_pc", pc, RPC);
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b1;
      imem_rvalid = 1'b1;
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      imem_rvalid = 1'b0;
      check("stray_rd_w_en", rd_w_en, 0);
      check("stray_minstret", minstret, 0);
      check("stray_dmem_req", dmem_req, 0);
      check("stray_inst", inst_o, 0);
      exp_fetch.delete();
      exp_inst.delete();
      m_pc  = RPC;
      m_ret = 0;
      exp_fetch.push_back(RPC);
      w = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h70);
      fetch(w, 0, 0);
      @(negedge clk);
      check("illegal_trap", trap, 1);
      check("illegal_cause", trap_cause, 1);
      check("illegal_rd_w_en", rd_w_en, 0);
      check("illegal_pc", pc, RPC);
      check("illegal_minstret", minstret, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_multi_cyc_ctrl.md
Name: rv_multi_cyc_ctrl

Overview:
- Sequencing controller and architectural-state holder for the multi-cycle RV64 core, successor to the single-cycle top.
- Owns the PC, the instruction register and the cycle/instret counters.
- Drives the fetch and data-memory request/grant/valid handshakes, so memories of arbitrary latency work.
- Pulses register-file write enables once per retired instruction.
- Decode and ALU stay combinational outside this block; their results are sampled here.

Parameters:
- XLEN, 64, datapath and counter width.
- PC_W, 32, PC / address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request, held until granted
- imem_addr  out  PC_W  fetch address (= pc)
- imem_gnt  in  1  fetch request accepted
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  ILEN  fetched instruction
- inst_o  out  ILEN  instruction register, to decoder
- pc  out  PC_W  current PC
- dec_ebreak  in  1  decoded ebreak
- dec_invalid  in  1  decoded illegal instruction
- dec_mem  in  1  instruction is load or store
- dec_rd_we  in  1  instruction writes rd
- jump_flag  in  1  taken jump/branch
- jump_addr  in  PC_W  jump target
- dmem_req  out  1  data request, held until granted
- dmem_gnt  in  1  data request accepted
- dmem_rvalid  in  1  data response valid
- rd_w_en  out  1  regfile write strobe, one cycle
- halt  out  1  ebreak reached, sticky
- trap  out  1  fault, sticky
- trap_cause  out  2  0 none, 1 illegal, 2 misaligned target
- mcycle  out  XLEN  cycles since reset
- minstret  out  XLEN  retired instructions

Behaviour:
- Reset (rst sampled high at posedge) sets:
  - state = FETCH, pc = RESET_PC, inst_o = 0
  - imem_req = dmem_req = rd_w_en = halt = trap = 0
  - trap_cause = 0, mcycle = minstret = 0
- Reset asserted mid-operation aborts the instruction at the next edge; no rd_w_en or counter update occurs on that edge. Late gnt/rvalid arriving after reset are ignored.
- All outputs are registered except imem_addr (= pc).
- FETCH:
  - imem_req = 1.
  - On imem_gnt → IWAIT.
  - If imem_gnt and imem_rvalid arrive in the same cycle: latch inst_o and go directly to EXEC.
- IWAIT: on imem_rvalid latch inst_o = imem_rdata → EXEC. imem_rvalid in any other state is ignored.
- EXEC samples the dec_* inputs, jump_flag and jump_addr, with this priority:
  1. dec_invalid → TRAP, cause 1
  2. dec_ebreak → HALT
  3. jump_flag && jump_addr[1:0] != 0 → TRAP, cause 2
  4. dec_mem → MEM
  5. otherwise → WB
- MEM:
  - dmem_req = 1.
  - On dmem_gnt → DWAIT.
  - gnt and rvalid in the same cycle → WB.
- DWAIT: on dmem_rvalid → WB.
- WB:
  - rd_w_en = dec_rd_we for exactly one cycle.
  - pc ← jump_flag ? jump_addr : pc + 4, wrapping modulo 2^PC_W.
  - minstret += 1.
  - → FETCH.
- HALT: halt = 1; pc is held; no requests are issued; ebreak is not counted as retired. State is left only by rst.
- TRAP: trap = 1 and trap_cause is held; pc holds the faulting instruction's PC. State is left only by rst.
- mcycle increments every cycle out of reset except in HALT/TRAP, where it freezes. Both counters wrap silently at 2^XLEN.
- Request lines are never dropped before their grant.
- Minimum latency with zero-wait memories:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles (adds MEM).

Decomposition:
- Shared package rv_core_pkg holds:
  - state enum {FETCH, IWAIT, EXEC, MEM, DWAIT, WB, HALT, TRAP}
  - trap_cause constants
  - RESET_PC default
  - instruction-length constant 4
- One natural sub-module, rv_perf_cnt: the mcycle/minstret pair with freeze and increment inputs.
- The FSM, PC and instruction register stay in the top.

Test Plan:
- Zero-wait memory, addi stream at 0x80000000, all dec_* = 0 → pc advances by 4 every 3 cycles; rd_w_en pulses once per instruction; minstret = 5 after 5 instructions.
- imem_gnt delayed 3 cycles, imem_rvalid a further 2 cycles → imem_req held high through the delay; inst_o updates only on the rvalid cycle; pc is unchanged until WB.
- jump_flag = 1, jump_addr = 0x80000100 → next imem_addr = 0x80000100. Repeat with jump_addr = 0x80000102 → trap = 1, trap_cause = 2, pc stays at the jump instruction's PC, no further requests.
- Load with dmem_gnt and dmem_rvalid 4 cycles apart → dmem_req held until grant; rd_w_en fires 1 cycle after rvalid; minstret += 1.
- dec_ebreak at the 3rd instruction → halt = 1, minstret = 2, mcycle frozen; rst pulse → pc = 0x80000000, halt = 0, counters = 0.
- rst asserted during DWAIT, stray dmem_rvalid afterwards → no rd_w_en; fetch restarts at RESET_PC; dec_invalid = 1 on that fetch → trap_cause = 1.
